// File: rtl/param_tfhe_set_switch.sv
// Run-time TFHE parameter-set table with a drained set switch.
// Holds NB_SET packed parameter records and drives the active one to the
// PBS/KS datapath. A switch waits until every in-flight PBS command has
// retired, so a command never observes a mix of old and new parameters.
//
// Handshake: a switch request is accepted in any cycle where sel_vld and
// sel_rdy are both 1; sel_set is sampled in that cycle. sel_rdy is high only
// in IDLE. Each accepted request produces exactly one sel_err or switch_done
// pulse.
//
// Record layout, MSB -> LSB:
//   lwe_k[LWE_K_W] n_log[4] glwe_k[3] pbs_l[4] pbs_b_w[6] ks_l[4] ks_b_w[6] mod_ksk_w[7]
module param_tfhe_set_switch #(
    parameter int NB_SET      = 4,
    parameter int SET_W       = $clog2(NB_SET),
    parameter int LWE_K_W     = 11,
    parameter int INFLIGHT_W  = 8,
    parameter int DEFAULT_SET = 0,
    parameter int REC_W       = LWE_K_W + 4 + 3 + 4 + 6 + 4 + 6 + 7,
    parameter logic [REC_W-1:0] DEFAULT_REC =
        {LWE_K_W'(887), 4'd11, 3'd1, 4'd1, 6'd22, 4'd5, 6'd3, 7'd21}
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    input  logic                  cfg_wr_en,
    input  logic [SET_W-1:0]      cfg_wr_set,
    input  logic [REC_W-1:0]      cfg_wr_data,
    output logic                  cfg_wr_err,
    input  logic                  sel_vld,
    output logic                  sel_rdy,
    input  logic [SET_W-1:0]      sel_set,
    output logic                  sel_err,
    output logic                  switch_done,
    output logic                  cmd_allow,
    input  logic                  pbs_start,
    input  logic                  pbs_done,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic                  cnt_err,
    output logic [SET_W-1:0]      act_set,
    output logic [REC_W-1:0]      act_rec,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    localparam logic [SET_W:0]      NB_SET_L = (SET_W + 1)'(NB_SET);
    localparam logic [SET_W-1:0]    DEF_SET  = SET_W'(DEFAULT_SET);
    localparam logic [INFLIGHT_W-1:0] INF_MAX = {INFLIGHT_W{1'b1}};

    state_e                  state_q, state_d;
    logic [SET_W-1:0]        pend_q, pend_d;
    logic [SET_W-1:0]        act_set_q, act_set_d;
    logic [REC_W-1:0]        act_rec_q, act_rec_d;
    logic                    done_q, done_d;
    logic                    sel_err_q, sel_err_d;
    logic                    wr_err_q, wr_err_d;
    logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;
    logic                    cnt_err_q, cnt_err_d;
    logic                    cnt_flag;
    logic [REC_W-1:0]        tbl_q [NB_SET];
    logic [REC_W-1:0]        pend_rec;
    logic                    wr_ok;
    logic                    wr_hit_pend;
    logic                    wr_hit_req;

    // In-flight counter: saturating, with over/underflow and illegal-start flags.
    always_comb begin
        inflight_d = inflight_q;
        cnt_flag   = 1'b0;
        case ({pbs_start, pbs_done})
            2'b10: begin
                if (inflight_q == INF_MAX) cnt_flag = 1'b1;
                else                       inflight_d = inflight_q + INFLIGHT_W'(1);
            end
            2'b01: begin
                if (inflight_q == '0) cnt_flag = 1'b1;
                else                  inflight_d = inflight_q - INFLIGHT_W'(1);
            end
            default: inflight_d = inflight_q;
        endcase
        // A start while commands are blocked is still counted but is an error.
        if (pbs_start && (state_q != ST_IDLE)) cnt_flag = 1'b1;
        cnt_err_d = cnt_err_q | cnt_flag;
    end

    // Record of the pending set, muxed by comparison so any SET_W works.
    always_comb begin
        pend_rec = '0;
        for (int i = 0; i < NB_SET; i++) begin
            if (pend_q == SET_W'(i)) pend_rec = tbl_q[i];
        end
    end

    // Switch FSM: next state, handshake outputs and the pulses it owns.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        act_set_d = act_set_q;
        act_rec_d = act_rec_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;
        sel_rdy   = 1'b0;
        cmd_allow = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_rdy   = 1'b1;
                cmd_allow = 1'b1;
                if (sel_vld) begin
                    if ({1'b0, sel_set} >= NB_SET_L) begin
                        sel_err_d = 1'b1;
                    end else if (sel_set == act_set_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = sel_set;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // A command retiring this cycle is already out of the pipe, so
                // look at the counter's next value to avoid a wasted cycle.
                if (inflight_d == '0) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                act_set_d = pend_q;
                act_rec_d = pend_rec;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Table write qualification: never touch the active, pending or just-requested set.
    always_comb begin
        wr_hit_pend = (state_q != ST_IDLE) && (cfg_wr_set == pend_q);
        wr_hit_req  = sel_vld && (state_q == ST_IDLE) && (cfg_wr_set == sel_set);
        wr_ok       = ({1'b0, cfg_wr_set} < NB_SET_L) &&
                      (cfg_wr_set != act_set_q) && !wr_hit_pend && !wr_hit_req;
        wr_err_d    = cfg_wr_en && !wr_ok;
    end

    // Control and active-set registers; reset aborts any switch in progress.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= DEF_SET;
            act_set_q  <= DEF_SET;
            act_rec_q  <= DEFAULT_REC;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            inflight_q <= '0;
            cnt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            act_set_q  <= act_set_d;
            act_rec_q  <= act_rec_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
            wr_err_q   <= wr_err_d;
            inflight_q <= inflight_d;
            cnt_err_q  <= cnt_err_d;
        end
    end

    // Parameter table storage, one entry per set.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < NB_SET; i++) tbl_q[i] <= DEFAULT_REC;
        end else begin
            for (int i = 0; i < NB_SET; i++) begin
                if (cfg_wr_en && wr_ok && (cfg_wr_set == SET_W'(i))) tbl_q[i] <= cfg_wr_data;
            end
        end
    end

    assign cfg_wr_err  = wr_err_q;
    assign sel_err     = sel_err_q;
    assign switch_done = done_q;
    assign inflight    = inflight_q;
    assign cnt_err     = cnt_err_q;
    assign act_set     = act_set_q;
    assign act_rec     = act_rec_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_param_tfhe_set_switch.sv
// Directed bench for param_tfhe_set_switch. Pulse events (switch_done,
// sel_err, cfg_wr_err) go through an expected queue tagged with the cycle
// they must appear in; level outputs are checked directly.
module tb_param_tfhe_set_switch;

    localparam int NB_SET     = 4;
    localparam int SET_W      = 3;   // wide enough to request index 5
    localparam int LWE_K_W    = 11;
    localparam int INFLIGHT_W = 8;
    localparam int REC_W      = 45;
    localparam int EW         = 2 + 16 + SET_W + REC_W;

    localparam logic [1:0] K_SW  = 2'd1;
    localparam logic [1:0] K_SEL = 2'd2;
    localparam logic [1:0] K_WR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                  cfg_wr_en = 1'b0;
    logic [SET_W-1:0]      cfg_wr_set = '0;
    logic [REC_W-1:0]      cfg_wr_data = '0;
    logic                  cfg_wr_err;
    logic                  sel_vld = 1'b0;
    logic                  sel_rdy;
    logic [SET_W-1:0]      sel_set = '0;
    logic                  sel_err;
    logic                  switch_done;
    logic                  cmd_allow;
    logic                  pbs_start = 1'b0;
    logic                  pbs_done = 1'b0;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  cnt_err;
    logic [SET_W-1:0]      act_set;
    logic [REC_W-1:0]      act_rec;
    logic [1:0]            dbg_state;

    param_tfhe_set_switch #(
        .NB_SET(NB_SET), .SET_W(SET_W), .LWE_K_W(LWE_K_W),
        .INFLIGHT_W(INFLIGHT_W), .DEFAULT_SET(0)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_set(cfg_wr_set), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_err(cfg_wr_err),
        .sel_vld(sel_vld), .sel_rdy(sel_rdy), .sel_set(sel_set), .sel_err(sel_err),
        .switch_done(switch_done), .cmd_allow(cmd_allow),
        .pbs_start(pbs_start), .pbs_done(pbs_done), .inflight(inflight),
        .cnt_err(cnt_err), .act_set(act_set), .act_rec(act_rec), .dbg_state(dbg_state)
    );

    function automatic logic [REC_W-1:0] mk_rec(input int lwe, input int nlog, input int glwe,
                                                input int pbsl, input int pbsb, input int ksl,
                                                input int ksb, input int modk);
        return {11'(lwe), 4'(nlog), 3'(glwe), 4'(pbsl), 6'(pbsb), 4'(ksl), 6'(ksb), 7'(modk)};
    endfunction

    logic [REC_W-1:0] rec_def, rec1, rec2, rec3, rec_bad;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_ev(input logic [1:0] k, input int at, input logic [SET_W-1:0] s,
                             input logic [REC_W-1:0] r);
        exp_q.push_back({k, 16'(at), s, r});
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    logic [1:0]    mon_kind;
    logic [EW-1:0] mon_act;
    logic [EW-1:0] mon_exp;
    int            mon_n;

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        mon_n = int'(switch_done) + int'(sel_err) + int'(cfg_wr_err);
        if (mon_n != 0) begin
            checks++;
            mon_kind = switch_done ? K_SW : (sel_err ? K_SEL : K_WR);
            mon_act  = {mon_kind, 16'(cyc), act_set, act_rec};
            if (mon_n > 1) begin
                errors++;
                $display("FAIL pulse_overlap at cycle %0d got %0d pulses expected 1", cyc, mon_n);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got %h expected none (kind|cycle|set|rec)", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL event got %h expected %h (kind|cycle|set|rec)", mon_act, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input logic [SET_W-1:0] s, input logic [REC_W-1:0] d);
        cfg_wr_en = 1'b1; cfg_wr_set = s; cfg_wr_data = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic select(input logic [SET_W-1:0] s);
        sel_vld = 1'b1; sel_set = s;
        @(negedge clk);
        sel_vld = 1'b0;
    endtask

    task automatic starts(input int n);
        pbs_start = 1'b1;
        repeat (n) @(negedge clk);
        pbs_start = 1'b0;
    endtask

    task automatic dones(input int n);
        pbs_done = 1'b1;
        repeat (n) @(negedge clk);
        pbs_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rec_def = mk_rec(887, 11, 1, 1, 22, 5, 3, 21);
        rec1    = mk_rec(742, 11, 1, 1, 22, 6, 3, 21);
        rec2    = mk_rec(630, 10, 1, 2, 15, 4, 4, 20);
        rec3    = mk_rec(1024, 12, 2, 3, 10, 7, 2, 32);
        rec_bad = mk_rec(1, 1, 1, 1, 1, 1, 1, 1);

        // 1: reset, idle
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_act_set", 64'(act_set), 0);
        chk("rst_act_rec", 64'(act_rec), 64'(rec_def));
        chk("rst_sel_rdy", 64'(sel_rdy), 1);
        chk("rst_cmd_allow", 64'(cmd_allow), 1);
        chk("rst_inflight", 64'(inflight), 0);
        chk("rst_cnt_err", 64'(cnt_err), 0);

        // 2: write sets 1 and 2, then minimum-latency switch to 1
        cfg_write(1, rec1);
        cfg_write(2, rec2);
        t = cyc;
        expect_ev(K_SW, t + 3, 1, rec1);
        select(1);
        chk("sw1_drain_cmd_allow", 64'(cmd_allow), 0);
        chk("sw1_drain_sel_rdy", 64'(sel_rdy), 0);
        repeat (2) @(negedge clk);
        chk("sw1_act_set", 64'(act_set), 1);
        chk("sw1_act_rec", 64'(act_rec), 64'(rec1));
        chk("sw1_cmd_allow", 64'(cmd_allow), 1);

        // 3: switch to 2 with three commands in flight
        starts(3);
        chk("pre_sw2_inflight", 64'(inflight), 3);
        t = cyc;
        expect_ev(K_SW, t + 11, 2, rec2);
        select(2);
        for (int k = 1; k <= 11; k++) begin
            pbs_done = (k == 4) || (k == 6) || (k == 9);
            if (k == 1)  chk("sw2_t1_cmd_allow", 64'(cmd_allow), 0);
            if (k == 9)  chk("sw2_t9_state_drain", 64'(dbg_state), 1);
            if (k == 10) chk("sw2_t10_state_apply", 64'(dbg_state), 2);
            if (k == 10) chk("sw2_t10_inflight", 64'(inflight), 0);
            if (k == 10) chk("sw2_t10_act_set_old", 64'(act_set), 1);
            if (k == 11) chk("sw2_t11_cmd_allow", 64'(cmd_allow), 1);
            @(negedge clk);
        end
        pbs_done = 1'b0;
        chk("sw2_act_set", 64'(act_set), 2);

        // 4: out-of-range request, then request of the active set
        t = cyc;
        expect_ev(K_SEL, t + 1, 2, rec2);
        select(5);
        @(negedge clk);
        chk("selerr_act_set", 64'(act_set), 2);
        chk("selerr_state_idle", 64'(dbg_state), 0);
        t = cyc;
        expect_ev(K_SW, t + 1, 2, rec2);
        select(2);
        repeat (3) @(negedge clk);
        chk("same_set_state_idle", 64'(dbg_state), 0);

        // 5: rejected writes (active, out of range, requested, pending), accepted write during APPLY
        t = cyc;
        expect_ev(K_WR, t + 1, 2, rec2);
        cfg_write(2, rec_bad);
        @(negedge clk);
        t = cyc;
        expect_ev(K_WR, t + 1, 2, rec2);
        cfg_write(5, rec_bad);
        @(negedge clk);
        t = cyc;
        expect_ev(K_WR, t + 1, 2, rec2);
        expect_ev(K_WR, t + 2, 2, rec2);
        expect_ev(K_SW, t + 3, 1, rec1);
        sel_vld = 1'b1; sel_set = 1;
        cfg_wr_en = 1'b1; cfg_wr_set = 1; cfg_wr_data = rec_bad;
        @(negedge clk);
        sel_vld = 1'b0;
        @(negedge clk);
        cfg_wr_set = 3; cfg_wr_data = rec3;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        t = cyc;
        expect_ev(K_SW, t + 3, 2, rec2);
        select(2);
        repeat (2) @(negedge clk);
        t = cyc;
        expect_ev(K_SW, t + 3, 3, rec3);
        select(3);
        repeat (2) @(negedge clk);
        chk("sw3_act_rec", 64'(act_rec), 64'(rec3));

        // counter rules
        starts(2);
        chk("cnt_two", 64'(inflight), 2);
        pbs_start = 1'b1; pbs_done = 1'b1;
        @(negedge clk);
        pbs_start = 1'b0; pbs_done = 1'b0;
        chk("cnt_start_done", 64'(inflight), 2);
        dones(2);
        chk("cnt_zero", 64'(inflight), 0);
        chk("cnt_err_clean", 64'(cnt_err), 0);
        dones(1);
        chk("cnt_underflow_inflight", 64'(inflight), 0);
        chk("cnt_underflow_err", 64'(cnt_err), 1);

        // 6: reset during DRAIN
        starts(1);
        select(1);
        @(negedge clk);
        chk("rst_mid_state_drain", 64'(dbg_state), 1);
        #2 a_rst_n = 1'b0;
        #1;
        chk("rst_mid_act_set", 64'(act_set), 0);
        chk("rst_mid_act_rec", 64'(act_rec), 64'(rec_def));
        chk("rst_mid_inflight", 64'(inflight), 0);
        chk("rst_mid_cnt_err", 64'(cnt_err), 0);
        chk("rst_mid_sel_rdy", 64'(sel_rdy), 1);
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_act_set", 64'(act_set), 0);
        chk("post_rst_cmd_allow", 64'(cmd_allow), 1);
        for (int s = 1; s < NB_SET; s++) begin
            t = cyc;
            expect_ev(K_SW, t + 3, SET_W'(s), rec_def);
            select(SET_W'(s));
            repeat (2) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
